// File: rtl/fma_pkg.sv
// Shared FMA datapath definitions: precision-mode encodings, lane geometry
// and the chunking used by the leading-zero counter.
package fma_pkg;

   // Datapath width (fixed by the lane map) and shift-amount width.
   localparam int DW = 106;
   localparam int SW = 7;

   // The vector is counted in 8-bit chunks; the last chunk is zero-padded low.
   localparam int CW   = 8;
   localparam int NCH  = (DW + CW - 1) / CW;
   localparam int PADW = NCH * CW;

   // Precision modes; 2'b11 is treated as MODE_DP.
   localparam logic [1:0] MODE_DP  = 2'b00;
   localparam logic [1:0] MODE_HP4 = 2'b01;
   localparam logic [1:0] MODE_SP2 = 2'b10;

   // Four 22-bit lanes on a 28-bit stride; two 48-bit lanes, upper one at bit 58.
   localparam int HP_LANE_W  = 22;
   localparam int HP_STRIDE  = 28;
   localparam int SP_LANE_W  = 48;
   localparam int SP_HI_BASE = 58;

   // Ones on lane bits, zeros on the inter-lane gap bits of the given mode.
   function automatic logic [DW-1:0] lane_mask(input logic [1:0] mode);
      logic [DW-1:0] m;
      m = '1;
      if (mode == MODE_HP4) begin
         for (int i = 0; i < DW; i++) begin
            if ((i % HP_STRIDE) >= HP_LANE_W) m[i] = 1'b0;
         end
      end else if (mode == MODE_SP2) begin
         for (int i = SP_LANE_W; i < SP_HI_BASE; i++) begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/chunk_lzc8.sv
// 8-bit leading-zero counter with all-zero flag; an all-zero chunk reports 8
// so that chunk counts can simply be summed across a lane.
module chunk_lzc8
   import fma_pkg::*;
(
   input  logic [CW-1:0] i_data,
   output logic [3:0]    o_cnt,
   output logic          o_zero
);

   // Scan LSB to MSB so the highest set bit writes the count last.
   always_comb begin
      o_cnt = 4'(CW);
      for (int i = 0; i < CW; i++) begin
         if (i_data[i]) o_cnt = 4'(CW - 1 - i);
      end
   end

   assign o_zero = (i_data == '0);

endmodule

// File: rtl/lane_lzc_stage.sv
// Two-stage multi-precision leading-zero counter feeding the normalize
// shifter. Stage 1 counts 8-bit chunks of the mode-masked vector; stage 2
// folds the chunk counts into per-lane shift amounts and zero flags.
module lane_lzc_stage
   import fma_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [1:0]    in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    out_mode,
   output logic [SW-1:0] shtamt0,
   output logic [SW-1:0] shtamt1,
   output logic [SW-1:0] shtamt2,
   output logic [SW-1:0] shtamt3,
   output logic [3:0]    lane_zero
);

   // Sum leading chunk counts over chunks f_first..f_last (index 0 = MSB chunk)
   // up to and including the first non-zero chunk, then remove the masked gap
   // bits sitting above the lane MSB in its first chunk. Result MSB = lane zero.
   function automatic logic [SW:0] lane_zc(input logic [NCH-1:0][3:0] cnt,
                                           input logic [NCH-1:0]      zero,
                                           input int                  f_first,
                                           input int                  f_last,
                                           input int                  off);
      logic [SW-1:0] acc;
      logic          found;
      acc   = '0;
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (k >= f_first && k <= f_last && !found) begin
            acc = acc + SW'(cnt[k]);
            if (!zero[k]) found = 1'b1;
         end
      end
      if (!found) return {1'b1, {SW{1'b0}}};
      return {1'b0, acc - SW'(off)};
   endfunction

   logic [DW-1:0]          w_masked;
   logic [PADW-1:0]        w_padded;
   logic [NCH-1:0][3:0]    w_cnt;
   logic [NCH-1:0]         w_zero;
   logic [3:0][SW:0]       w_res;
   logic [3:0][SW-1:0]     w_sht;
   logic [3:0]             w_lz;
   logic                   w_s1_load;
   logic                   w_s2_load;

   logic                   r_s1_vld;
   logic [DW-1:0]          r_s1_data;
   logic [1:0]             r_s1_mode;
   logic [NCH-1:0][3:0]    r_s1_cnt;
   logic [NCH-1:0]         r_s1_zero;

   logic                   r_s2_vld;
   logic [DW-1:0]          r_s2_data;
   logic [1:0]             r_s2_mode;
   logic [3:0][SW-1:0]     r_s2_sht;
   logic [3:0]             r_s2_lz;

   // Gap bits are cleared so they never terminate a lane's zero run; with the
   // lane map chosen, no 8-bit chunk ever holds bits of two different lanes.
   assign w_masked = in_data & lane_mask(in_mode);
   assign w_padded = {w_masked, {(PADW - DW){1'b0}}};

   for (genvar k = 0; k < NCH; k++) begin : g_chunk
      chunk_lzc8 u_chunk (
         .i_data (w_padded[PADW-1-CW*k -: CW]),
         .o_cnt  (w_cnt[k]),
         .o_zero (w_zero[k])
      );
   end

   // A stage loads when empty or when its current entry moves on this cycle.
   assign w_s2_load = !r_s2_vld || out_ready;
   assign w_s1_load = !r_s1_vld || w_s2_load;
   assign in_ready  = w_s1_load;

   // Stage 1: capture chunk counts, zero flags, data and mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
         r_s1_mode <= '0;
         r_s1_cnt  <= '0;
         r_s1_zero <= '0;
      end else if (w_s1_load) begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s1_data <= in_data;
            r_s1_mode <= in_mode;
            r_s1_cnt  <= w_cnt;
            r_s1_zero <= w_zero;
         end
      end
   end

   // Fold chunk results into lanes using the mode registered with this entry;
   // unused lanes stay at count 0 with lane_zero clear.
   always_comb begin
      w_res = '0;
      case (r_s1_mode)
         MODE_HP4: begin
            w_res[3] = lane_zc(r_s1_cnt, r_s1_zero, 0, 2, 0);
            w_res[2] = lane_zc(r_s1_cnt, r_s1_zero, 3, 6, 4);
            w_res[1] = lane_zc(r_s1_cnt, r_s1_zero, 7, 9, 0);
            w_res[0] = lane_zc(r_s1_cnt, r_s1_zero, 10, 13, 4);
         end
         MODE_SP2: begin
            w_res[1] = lane_zc(r_s1_cnt, r_s1_zero, 0, 5, 0);
            w_res[0] = lane_zc(r_s1_cnt, r_s1_zero, 7, 13, 2);
         end
         default: begin
            w_res[0] = lane_zc(r_s1_cnt, r_s1_zero, 0, NCH - 1, 0);
         end
      endcase
   end

   // Split each lane result into its shift amount and zero flag.
   always_comb begin
      w_sht = '0;
      w_lz  = '0;
      for (int n = 0; n < 4; n++) begin
         w_sht[n] = w_res[n][SW-1:0];
         w_lz[n]  = w_res[n][SW];
      end
   end

   // Stage 2: register per-lane results; hold them while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld  <= 1'b0;
         r_s2_data <= '0;
         r_s2_mode <= '0;
         r_s2_sht  <= '0;
         r_s2_lz   <= '0;
      end else if (w_s2_load) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
            r_s2_mode <= r_s1_mode;
            r_s2_sht  <= w_sht;
            r_s2_lz   <= w_lz;
         end
      end
   end

   assign out_valid = r_s2_vld;
   assign out_data  = r_s2_data;
   assign out_mode  = r_s2_mode;
   assign shtamt0   = r_s2_sht[0];
   assign shtamt1   = r_s2_sht[1];
   assign shtamt2   = r_s2_sht[2];
   assign shtamt3   = r_s2_sht[3];
   assign lane_zero = r_s2_lz;

endmodule

// File: tb/tb_lane_lzc_stage.sv
// Directed bench for lane_lzc_stage: reset state, per-mode lane counts,
// streaming with mode changes, backpressure and mid-flight reset.
module tb_lane_lzc_stage;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [105:0] in_data = '0;
   logic [1:0]   in_mode = 2'b00;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [105:0] out_data;
   logic [1:0]   out_mode;
   logic [6:0]   shtamt0, shtamt1, shtamt2, shtamt3;
   logic [3:0]   lane_zero;
   logic [31:0]  obs;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [105:0] d;
      logic [1:0]   m;
      logic [6:0]   s3, s2, s1, s0;
      logic [3:0]   lz;
   } vec_t;

   vec_t vt[12];

   lane_lzc_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mode  (out_mode),
      .shtamt0   (shtamt0),
      .shtamt1   (shtamt1),
      .shtamt2   (shtamt2),
      .shtamt3   (shtamt3),
      .lane_zero (lane_zero)
   );

   always #5 clk = ~clk;

   assign obs = {shtamt3, shtamt2, shtamt1, shtamt0, lane_zero};

   function automatic logic [31:0] exp_obs(input vec_t v);
      return {v.s3, v.s2, v.s1, v.s0, v.lz};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int i, input logic [105:0] d, input logic [1:0] m,
                          input int s0, input int s1, input int s2, input int s3,
                          input logic [3:0] lz);
      vt[i].d  = d;
      vt[i].m  = m;
      vt[i].s0 = 7'(s0);
      vt[i].s1 = 7'(s1);
      vt[i].s2 = 7'(s2);
      vt[i].s3 = 7'(s3);
      vt[i].lz = lz;
   endtask

   task automatic init_vectors();
      logic [105:0] one;
      one = 106'd1;
      set_vec(0, one << 105, 2'b00, 0, 0, 0, 0, 4'b0000);
      set_vec(1, one, 2'b00, 105, 0, 0, 0, 4'b0000);
      set_vec(2, '0, 2'b00, 0, 0, 0, 0, 4'b0001);
      set_vec(3, {22'h000400, 6'h3F, 22'h000000, 6'h3F, 22'h200000, 6'h3F, 22'h000001},
              2'b01, 21, 0, 0, 11, 4'b0100);
      set_vec(4, {22'h000000, 6'h3F, 22'h000001, 6'h3F, 22'h000001, 6'h3F, 22'h200000},
              2'b01, 0, 21, 21, 0, 4'b1000);
      set_vec(5, {48'h8000_0000_0000, 10'h3FF, 48'h0000_0000_8000},
              2'b10, 32, 0, 0, 0, 4'b0000);
      set_vec(6, {48'h0000_0000_0001, 10'h3FF, 48'h0000_0000_0000},
              2'b10, 0, 47, 0, 0, 4'b0001);
      set_vec(7, one << 64, 2'b11, 41, 0, 0, 0, 4'b0000);
      set_vec(8, one << 100, 2'b00, 5, 0, 0, 0, 4'b0000);
      set_vec(9, one << 50, 2'b00, 55, 0, 0, 0, 4'b0000);
      set_vec(10, one << 7, 2'b00, 98, 0, 0, 0, 4'b0000);
      set_vec(11, one << 1, 2'b00, 104, 0, 0, 0, 4'b0000);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (obs !== 32'h0 || out_mode !== 2'b00) begin
         failures++;
         $display("FAIL reset_counts: got %h/%b expected 0/00", obs, out_mode);
      end
      checks++;
      if (out_data !== 106'h0) begin
         failures++;
         $display("FAIL reset_out_data: got %h expected 0", out_data);
      end
   endtask

   task automatic test_single_lanes();
      for (int i = 0; i < 8; i++) begin
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_data   = vt[i].d;
         in_mode   = vt[i].m;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single%0d_in_ready: got %b expected 1", i, in_ready);
         end
         step();
         in_valid = 1'b0;
         in_data  = '0;
         in_mode  = 2'b00;
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single%0d_early_valid: got %b expected 0", i, out_valid);
         end
         step();
         checks++;
         if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL single%0d_latency: got out_valid %b expected 1", i, out_valid);
         end
         checks++;
         if (obs !== exp_obs(vt[i])) begin
            failures++;
            $display("FAIL single%0d_counts: got %h expected %h", i, obs, exp_obs(vt[i]));
         end
         checks++;
         if (out_data !== vt[i].d || out_mode !== vt[i].m) begin
            failures++;
            $display("FAIL single%0d_forward: got %h/%b expected %h/%b",
                     i, out_data, out_mode, vt[i].d, vt[i].m);
         end
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single%0d_drain: got out_valid %b expected 0", i, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ids[4] = '{1, 3, 6, 7};
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         in_valid = (c < 4);
         in_data  = (c < 4) ? vt[ids[c]].d : '0;
         in_mode  = (c < 4) ? vt[ids[c]].m : 2'b00;
         #1;
         if (c < 4) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_c%0d_in_ready: got %b expected 1", c, in_ready);
            end
         end
         checks++;
         if (out_valid !== (c >= 2 && c < 6)) begin
            failures++;
            $display("FAIL b2b_c%0d_out_valid: got %b expected %b", c, out_valid, (c >= 2 && c < 6));
         end
         if (c >= 2 && c < 6) begin
            checks++;
            if (obs !== exp_obs(vt[ids[c-2]]) || out_data !== vt[ids[c-2]].d
                || out_mode !== vt[ids[c-2]].m) begin
               failures++;
               $display("FAIL b2b_c%0d_result: got %h/%b expected %h/%b", c, obs, out_mode,
                        exp_obs(vt[ids[c-2]]), vt[ids[c-2]].m);
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      int ids[4]       = '{8, 9, 10, 11};
      int exp_ir[11]   = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
      int exp_ov[11]   = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      int exp_item[11] = '{-1, -1, 0, 0, 0, 0, 0, 1, 2, 3, -1};
      int ptr = 0;
      for (int c = 0; c < 11; c++) begin
         out_ready = !(c >= 2 && c <= 5);
         in_valid  = (ptr < 4);
         in_data   = (ptr < 4) ? vt[ids[ptr]].d : '0;
         in_mode   = 2'b00;
         #1;
         checks++;
         if (in_ready !== 1'(exp_ir[c])) begin
            failures++;
            $display("FAIL bp_c%0d_in_ready: got %b expected %0d", c, in_ready, exp_ir[c]);
         end
         checks++;
         if (out_valid !== 1'(exp_ov[c])) begin
            failures++;
            $display("FAIL bp_c%0d_out_valid: got %b expected %0d", c, out_valid, exp_ov[c]);
         end
         if (exp_item[c] >= 0) begin
            checks++;
            if (obs !== exp_obs(vt[ids[exp_item[c]]]) || out_data !== vt[ids[exp_item[c]]].d) begin
               failures++;
               $display("FAIL bp_c%0d_result: got %h expected %h", c, obs,
                        exp_obs(vt[ids[exp_item[c]]]));
            end
         end
         if (in_valid && in_ready) ptr++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = vt[8].d;
      in_mode   = 2'b00;
      #1;
      step();
      in_data = vt[9].d;
      #1;
      step();
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst_full: got valid %b ready %b expected 1 0", out_valid, in_ready);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (obs !== 32'h0 || out_data !== 106'h0) begin
         failures++;
         $display("FAIL midrst_outputs: got %h/%h expected 0/0", obs, out_data);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_stale_c%0d: got out_valid %b expected 0", c, out_valid);
         end
      end
   endtask

   initial begin
      init_vectors();
      test_reset();
      test_single_lanes();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
